// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with saturating modes and Z/N/V/C flags.
// Each register stage resolves one WIDTH/STAGES-bit slice and forwards its carry onward.
module cla_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             C
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  // Stage registers; index k holds what has been resolved after k slices.
  logic [WIDTH-1:0] a_q   [1:STAGES];
  logic [WIDTH-1:0] b_q   [1:STAGES];
  logic [WIDTH-1:0] sum_q [1:STAGES];
  logic [1:0]       op_q  [1:STAGES];
  logic             c_q   [1:STAGES];
  logic [STAGES:1]  v_q;
  logic             z_q, n_q, vf_q, cf_q;

  logic [WIDTH-1:0] src_a   [0:STAGES-1];
  logic [WIDTH-1:0] src_b   [0:STAGES-1];
  logic [WIDTH-1:0] src_sum [0:STAGES-1];
  logic [1:0]       src_op  [0:STAGES-1];
  logic             src_c   [0:STAGES-1];
  logic [STAGES:1]  src_v;

  logic [WIDTH-1:0] nxt_sum [1:STAGES];
  logic             nxt_c   [1:STAGES];
  logic             nxt_z, nxt_n, nxt_v, nxt_cf;
  logic [SW+1:0]    res;
  logic [STAGES:1]  adv;

  // Returns {carry_out, carry_into_msb, sum} for one slice of 4-bit groups.
  function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] a,
                                              input logic [SW-1:0] b,
                                              input logic          cin);
    logic [SW-1:0] g, p, s;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          term, prod, bc, cmsb;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        gg[j] = g[4*j+i] | (p[4*j+i] & gg[j]);
        gp[j] = gp[j] & p[4*j+i];
      end
    end
    gc[0] = cin;
    for (int j = 1; j <= NG; j++) begin
      term = 1'b0;
      prod = 1'b1;
      for (int i = j - 1; i >= 0; i--) begin
        term = term | (gg[i] & prod);
        prod = prod & gp[i];
      end
      gc[j] = term | (prod & cin);
    end
    s    = '0;
    cmsb = 1'b0;
    for (int j = 0; j < NG; j++) begin
      bc = gc[j];
      for (int i = 0; i < 4; i++) begin
        s[4*j+i] = p[4*j+i] ^ bc;
        if (4*j + i == SW - 1) cmsb = bc;
        bc = g[4*j+i] | (p[4*j+i] & bc);
      end
    end
    return {gc[NG], cmsb, s};
  endfunction

  // Slice 0 reads the ports; later slices read the skewed operands of the previous stage.
  always_comb begin
    src_a[0]   = A;
    src_b[0]   = B ^ {WIDTH{op[0]}};
    src_sum[0] = '0;
    src_op[0]  = op;
    src_c[0]   = op[0];
    src_v[1]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k];
      src_b[k]   = b_q[k];
      src_sum[k] = sum_q[k];
      src_op[k]  = op_q[k];
      src_c[k]   = c_q[k];
      src_v[k+1] = v_q[k];
    end
  end

  always_comb begin
    res    = '0;
    nxt_cf = 1'b0;
    nxt_v  = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      res = slice_add(src_a[s][s*SW +: SW], src_b[s][s*SW +: SW], src_c[s]);
      nxt_sum[s+1]            = src_sum[s];
      nxt_sum[s+1][s*SW +: SW] = res[SW-1:0];
      nxt_c[s+1]              = res[SW+1];
      if (s == STAGES - 1) begin
        nxt_cf = res[SW+1];
        nxt_v  = res[SW+1] ^ res[SW];
        // Saturating ops clamp toward the sign of A; C keeps the raw carry.
        if (src_op[s][1] && nxt_v)
          nxt_sum[s+1] = src_a[s][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
    nxt_z = (nxt_sum[STAGES] == '0);
    nxt_n = nxt_sum[STAGES][WIDTH-1];
  end

  // A stage may load when it is empty or its occupant moves on, so bubbles collapse.
  always_comb begin : flow_ctl
    logic acc;
    acc = out_ready;
    adv = '0;
    for (int k = STAGES; k >= 1; k--) begin
      acc    = !v_q[k] | acc;
      adv[k] = acc;
    end
  end

  assign in_ready = adv[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        op_q[k]  <= '0;
        c_q[k]   <= 1'b0;
      end
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      vf_q <= 1'b0;
      cf_q <= 1'b0;
    end else if (flush) begin
      v_q <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k]   <= src_a[k-1];
            b_q[k]   <= src_b[k-1];
            sum_q[k] <= nxt_sum[k];
            op_q[k]  <= src_op[k-1];
            c_q[k]   <= nxt_c[k];
          end
        end
      end
      if (adv[STAGES] && src_v[STAGES]) begin
        z_q  <= nxt_z;
        n_q  <= nxt_n;
        vf_q <= nxt_v;
        cf_q <= nxt_cf;
      end
    end
  end

  assign out_valid = v_q[STAGES];
  assign Sum       = sum_q[STAGES];
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = vf_q;
  assign C         = cf_q;

endmodule

// File: tb/tb_cla_pipe.sv
// Scoreboard bench for cla_pipe: a 16-bit/2-stage and a 32-bit/4-stage instance
// share clock and reset; accepted ops are modelled and compared as results pop out.
module tb_cla_pipe;

  localparam int S16 = 2;
  localparam int S32 = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        z;
    logic        n;
    logic        v;
    logic        c;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    logic [31:0] s;
    logic        z;
    logic        n;
    logic        v;
    logic        c;
  } dir_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        flush16, in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic [1:0]  op16;
  logic        z16, n16, v16, c16;

  logic        flush32, in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32, sum32;
  logic [1:0]  op32;
  logic        z32, n32, v32, c32;

  int   errors = 0;
  int   checks = 0;
  int   pops16 = 0;
  int   pops32 = 0;
  res_t sb16[$];
  res_t sb32[$];
  res_t e16, e32;

  cla_pipe #(.WIDTH(16), .STAGES(S16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush16), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .Sum(sum16), .Z(z16), .N(n16), .V(v16), .C(c16)
  );

  cla_pipe #(.WIDTH(32), .STAGES(S32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush32), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .op(op32), .out_valid(out_valid32), .out_ready(out_ready32),
    .Sum(sum32), .Z(z32), .N(n32), .V(v32), .C(c32)
  );

  always #5 clk = ~clk;

  // Reference: wide integer add, overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] o);
    logic [63:0] mask, aa, bb, full;
    res_t r;
    mask  = (64'd1 << w) - 64'd1;
    aa    = {32'd0, a} & mask;
    bb    = o[0] ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    full  = aa + bb + {63'd0, o[0]};
    r.sum = full[31:0] & mask[31:0];
    r.c   = full[w];
    r.v   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    if (o[1] && r.v) r.sum = aa[w-1] ? 32'(64'd1 << (w - 1)) : 32'(mask >> 1);
    r.z   = (r.sum == 32'd0);
    r.n   = r.sum[w-1];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid16 && out_ready16 && !flush16) begin
        pops16++;
        checks++;
        if (sb16.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb16_extra: got Sum=%h with no op outstanding", sum16);
        end else begin
          e16 = sb16.pop_front();
          if ({sum16, z16, n16, v16, c16} !== {e16.sum[15:0], e16.z, e16.n, e16.v, e16.c}) begin
            errors++;
            $display("[TB] FAIL sb16_result: got Sum=%h ZNVC=%b%b%b%b want Sum=%h ZNVC=%b%b%b%b",
                     sum16, z16, n16, v16, c16, e16.sum[15:0], e16.z, e16.n, e16.v, e16.c);
          end
        end
      end
      if (in_valid16 && in_ready16 && !flush16)
        sb16.push_back(model(16, {16'd0, a16}, {16'd0, b16}, op16));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid32 && out_ready32 && !flush32) begin
        pops32++;
        checks++;
        if (sb32.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb32_extra: got Sum=%h with no op outstanding", sum32);
        end else begin
          e32 = sb32.pop_front();
          if ({sum32, z32, n32, v32, c32} !== {e32.sum, e32.z, e32.n, e32.v, e32.c}) begin
            errors++;
            $display("[TB] FAIL sb32_result: got Sum=%h ZNVC=%b%b%b%b want Sum=%h ZNVC=%b%b%b%b",
                     sum32, z32, n32, v32, c32, e32.sum, e32.z, e32.n, e32.v, e32.c);
          end
        end
      end
      if (in_valid32 && in_ready32 && !flush32)
        sb32.push_back(model(32, a32, b32, op32));
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if ({out_valid16, sum16, z16, n16, v16, c16} !== '0) begin
      errors++;
      $display("[TB] FAIL reset16: got valid=%b Sum=%h ZNVC=%b%b%b%b want all zero",
               out_valid16, sum16, z16, n16, v16, c16);
    end
    checks++;
    if ({out_valid32, sum32, z32, n32, v32, c32} !== '0) begin
      errors++;
      $display("[TB] FAIL reset32: got valid=%b Sum=%h ZNVC=%b%b%b%b want all zero",
               out_valid32, sum32, z32, n32, v32, c32);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready16, in_ready32} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b%b want 11", in_ready16, in_ready32);
    end
  endtask

  task automatic test_directed16();
    dir_t d[6];
    int   lat;
    logic got;
    d[0] = '{32'h7FFF, 32'h0001, 2'b00, 32'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
    d[1] = '{32'h7FFF, 32'h0001, 2'b10, 32'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0};
    d[2] = '{32'h8000, 32'h0001, 2'b11, 32'h8000, 1'b0, 1'b1, 1'b1, 1'b1};
    d[3] = '{32'h0005, 32'h0005, 2'b01, 32'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    d[4] = '{32'h0000, 32'h0001, 2'b01, 32'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    d[5] = '{32'h1234, 32'h0100, 2'b10, 32'h1334, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready16 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a16 = d[i].a[15:0];
      b16 = d[i].b[15:0];
      op16 = d[i].o;
      in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      lat = 1;
      got = 1'b0;
      while (!got && lat < 20) begin
        @(negedge clk);
        if (out_valid16) got = 1'b1;
        else begin @(posedge clk); #1; lat++; end
      end
      checks++;
      if (!got || lat != S16) begin
        errors++;
        $display("[TB] FAIL dir16_latency[%0d]: got %0d edges (seen=%b) want %0d", i, lat, got, S16);
      end
      checks++;
      if ({sum16, z16, n16, v16, c16} !== {d[i].s[15:0], d[i].z, d[i].n, d[i].v, d[i].c}) begin
        errors++;
        $display("[TB] FAIL dir16_value[%0d]: got Sum=%h ZNVC=%b%b%b%b want Sum=%h ZNVC=%b%b%b%b",
                 i, sum16, z16, n16, v16, c16, d[i].s[15:0], d[i].z, d[i].n, d[i].v, d[i].c);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   cyc = 0;
    int   p0 = pops16;
    int   n = 0;
    logic acc;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    op16 = 2'($urandom_range(0, 3));
    in_valid16 = 1'b1;
    while (sent < 8 && cyc < 100) begin
      out_ready16 = !(cyc >= 3 && cyc < 6);
      #1;
      checks++;
      if (in_ready16 !== !(sb16.size() == S16 && !out_ready16)) begin
        errors++;
        $display("[TB] FAIL b2b_in_ready[%0d]: got %b with occupancy %0d out_ready %b",
                 cyc, in_ready16, sb16.size(), out_ready16);
      end
      @(negedge clk);
      acc = in_ready16;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 8) begin
          a16 = 16'($urandom);
          b16 = 16'($urandom);
          op16 = 2'($urandom_range(0, 3));
        end else in_valid16 = 1'b0;
      end
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    while (sb16.size() != 0 && n < 30) begin @(posedge clk); #1; n++; end
    checks++;
    if (sent != 8 || sb16.size() != 0 || pops16 - p0 != 8) begin
      errors++;
      $display("[TB] FAIL b2b_count: sent=%0d outputs=%0d pending=%0d want 8/8/0",
               sent, pops16 - p0, sb16.size());
    end
  endtask

  task automatic test_flush();
    int p0;
    int n = 0;
    out_ready16 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      op16 = 2'($urandom_range(0, 3));
      in_valid16 = 1'b1;
      @(posedge clk); #1;
    end
    a16 = 16'h0F0F;
    flush16 = 1'b1;
    #1;
    checks++;
    if ({out_valid16, in_ready16} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL flush_full: got valid=%b ready=%b want 1 0", out_valid16, in_ready16);
    end
    @(posedge clk); #1;
    flush16 = 1'b0;
    in_valid16 = 1'b0;
    checks++;
    if ({out_valid16, in_ready16} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL flush_clear: got valid=%b ready=%b want 0 1", out_valid16, in_ready16);
    end
    sb16.delete();
    out_ready16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid16 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_ghost[%0d]: got out_valid=%b want 0", i, out_valid16);
      end
    end
    @(posedge clk); #1;
    p0 = pops16;
    a16 = 16'h0042;
    b16 = 16'h0003;
    op16 = 2'b01;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    while (sb16.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (sb16.size() != 0 || pops16 - p0 != 1) begin
      errors++;
      $display("[TB] FAIL flush_next: outputs=%0d pending=%0d want 1/0", pops16 - p0, sb16.size());
    end
  endtask

  task automatic test_reset_midstream();
    out_ready16 = 1'b0;
    a16 = 16'h1234;
    b16 = 16'h1111;
    op16 = 2'b00;
    in_valid16 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid16 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid16 !== 1'b1 || sum16 !== 16'h2345) begin
      errors++;
      $display("[TB] FAIL midrst_pre: got valid=%b Sum=%h want 1 2345", out_valid16, sum16);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid16, sum16, z16, n16, v16, c16, out_valid32} !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got valid=%b Sum=%h ZNVC=%b%b%b%b valid32=%b want zeros",
               out_valid16, sum16, z16, n16, v16, c16, out_valid32);
    end
    sb16.delete();
    sb32.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    out_ready16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL midrst_after[%0d]: got valid=%b ready=%b want 0 1",
                 i, out_valid16, in_ready16);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wide();
    dir_t d[4];
    int   lat;
    int   sent = 0;
    int   cyc = 0;
    int   p0;
    int   n = 0;
    logic got;
    logic acc;
    d[0] = '{32'hFFFFFFFF, 32'h00000001, 2'b00, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    d[1] = '{32'h7FFFFFFF, 32'h00000001, 2'b10, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    d[2] = '{32'h80000000, 32'h00000001, 2'b11, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b1};
    d[3] = '{32'h00000005, 32'h00000005, 2'b01, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    out_ready32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a32 = d[i].a;
      b32 = d[i].b;
      op32 = d[i].o;
      in_valid32 = 1'b1;
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      lat = 1;
      got = 1'b0;
      while (!got && lat < 20) begin
        @(negedge clk);
        if (out_valid32) got = 1'b1;
        else begin @(posedge clk); #1; lat++; end
      end
      checks++;
      if (!got || lat != S32) begin
        errors++;
        $display("[TB] FAIL dir32_latency[%0d]: got %0d edges (seen=%b) want %0d", i, lat, got, S32);
      end
      checks++;
      if ({sum32, z32, n32, v32, c32} !== {d[i].s, d[i].z, d[i].n, d[i].v, d[i].c}) begin
        errors++;
        $display("[TB] FAIL dir32_value[%0d]: got Sum=%h ZNVC=%b%b%b%b want Sum=%h ZNVC=%b%b%b%b",
                 i, sum32, z32, n32, v32, c32, d[i].s, d[i].z, d[i].n, d[i].v, d[i].c);
      end
      @(posedge clk); #1;
    end
    p0 = pops32;
    a32 = $urandom;
    b32 = $urandom;
    op32 = 2'($urandom_range(0, 3));
    in_valid32 = 1'b1;
    while (sent < 10 && cyc < 100) begin
      out_ready32 = !(cyc >= 4 && cyc < 9);
      #1;
      checks++;
      if (in_ready32 !== !(sb32.size() == S32 && !out_ready32)) begin
        errors++;
        $display("[TB] FAIL w32_in_ready[%0d]: got %b with occupancy %0d out_ready %b",
                 cyc, in_ready32, sb32.size(), out_ready32);
      end
      @(negedge clk);
      acc = in_ready32;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        a32 = $urandom;
        b32 = $urandom;
        op32 = 2'($urandom_range(0, 3));
      end
    end
    in_valid32 = 1'b0;
    out_ready32 = 1'b1;
    while (sb32.size() != 0 && n < 30) begin @(posedge clk); #1; n++; end
    checks++;
    if (sent != 10 || sb32.size() != 0 || pops32 - p0 != 10) begin
      errors++;
      $display("[TB] FAIL w32_count: sent=%0d outputs=%0d pending=%0d want 10/10/0",
               sent, pops32 - p0, sb32.size());
    end
  endtask

  initial begin
    flush16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; op16 = '0;
    flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; op32 = '0;
    test_reset();
    test_directed16();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the execute stage and address-generation paths. It generalises the fixed 16-bit CLA in three ways: configurable width, configurable pipeline depth with valid/ready flow control, and signed saturating modes. It also reports full Z/N/V/C flags. Each pipeline stage resolves one slice of 4-bit lookahead groups and forwards the slice carry to the next stage.

## Interface
- `WIDTH`, default 16: operand width; a multiple of 4, range 8..64.
- `STAGES`, default 2: number of pipeline register stages; must divide `WIDTH/4`, so each stage handles `WIDTH/STAGES` bits.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `flush`  in  1: synchronous pipeline clear.
- `in_valid`  in  1: operands and op are valid.
- `in_ready`  out  1: block can accept this cycle.
- `A`  in  `WIDTH`: operand A.
- `B`  in  `WIDTH`: operand B.
- `op`  in  2: 00 ADD, 01 SUB, 10 SATADD, 11 SATSUB.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `Sum`  out  `WIDTH`: result.
- `Z`, `N`, `V`, `C`  out  1 each: zero, negative, signed overflow, carry-out.

## Operation
- Accept when `in_valid & in_ready` at a rising edge.
- SUB and SATSUB compute `A + ~B + 1`; the op's LSB is the carry-in to slice 0.
- Slice arithmetic:
  - Slice `s` covers bits `[s*W/S +: W/S]` and is built from 4-bit groups with group P/G and a two-level lookahead inside the slice.
  - Stage `s+1` registers the slice-`s` sum, the slice carry-out, and the still-unconsumed upper operand bits.
  - Operand skew registers carry `A`/`B`/`op` forward; input ports are never re-sampled.
- Final stage:
  - `C` = carry-out of the MSB. For SUB this means "no borrow".
  - `V` = carry into MSB XOR carry out of MSB.
- Saturation, SATADD/SATSUB only:
  - If `V`=1: `Sum` = `{1'b0,{W-1{1'b1}}}` when `A[W-1]`=0, else `{1'b1,{W-1{1'b0}}}`.
  - `V` still reports 1. `C` reports the raw carry.
- `Z` = (`Sum`==0) and `N` = `Sum[W-1]`, both computed on the post-saturation `Sum`.
- ADD/SUB wrap modulo 2^`WIDTH`.
- Flow control: per-stage valid bit `v[1..STAGES]`.
  - Stage `k` advances when `!v[k] | adv[k+1]`; `adv[STAGES+1]` = `out_ready`.
  - `in_ready` = `!v[1] | adv[2]`, combinational from `out_ready`.
  - Bubbles collapse: a stall at the output does not block upstream stages that hold bubbles.
- `out_valid` = `v[STAGES]`. `Sum`/flags are stable while `out_valid & !out_ready`.
- `flush`: on the next edge all `v` clear; any input presented that edge is dropped; `flush` has priority over accept.
- Reset (`rst_n`=0, async): all `v`=0; `Sum`, `Z`, `N`, `V`, `C` = 0; `in_ready`=1 once `rst_n` deasserts.
- Reset asserted mid-operation discards all in-flight results; no partial outputs appear.

## Timing
- Latency: an operation accepted at edge k has `out_valid`=1 after edge k+`STAGES`-1. With `STAGES`=1 it is registered, visible the cycle after accept.
- Throughput: one result per cycle while `out_ready`=1.
- Full pipeline with `out_ready`=0: `in_ready`=0. When `out_ready` rises, `in_ready` rises combinationally in the same cycle.
- Simultaneous output pop and input accept on a full pipeline: both occur, and occupancy is unchanged.
- Critical path per stage: one `W/STAGES`-bit lookahead plus the incoming carry register.

## Test plan
1. `WIDTH`=16, `STAGES`=2, ADD `A`=0x7FFF, `B`=0x0001 -> `Sum`=0x8000, `V`=1, `N`=1, `C`=0, `Z`=0; `out_valid` 2 edges after accept (inclusive).
2. SATADD 0x7FFF+0x0001 -> `Sum`=0x7FFF, `V`=1, `N`=0. SATSUB 0x8000-0x0001 -> `Sum`=0x8000, `V`=1, `N`=1.
3. SUB 0x0005-0x0005 -> `Sum`=0x0000, `Z`=1, `C`=1, `V`=0. SUB 0x0000-0x0001 -> 0xFFFF, `C`=0, `N`=1.
4. Back-to-back stream of 8 random ops with `out_ready` held 0 for 3 cycles mid-stream:
   - No loss or duplication; order preserved.
   - `in_ready` drops only when all `STAGES` are full.
   - Results match a reference model.
5. `flush` asserted while 2 ops are in flight plus one presented -> no `out_valid` for any of them; the next accepted op completes normally.
6. `rst_n` pulsed low asynchronously mid-stream -> all outputs 0 immediately. Repeat the directed cases with `WIDTH`=32, `STAGES`=4: 0xFFFFFFFF+1 -> `Sum`=0, `C`=1, `Z`=1, latency 4.
